note_sequencer: RTL and testbench
=================================

Name: note_sequencer

Overview:
- Runs the PLAY phase of the game. After a start pulse for a selected level, it steps through that level's arrow pattern, one step per beat tick.
- For each step it shows the target arrows and opens a hit window. It judges the player's button presses, accumulates score and combo, and raises done after the last step.
- It sits between the top-level menu FSM (start, lev, done), the beat timer (tick) and the graphics and LED outputs.

Parameters:
- NUM_STEPS, 16, steps per level; index width is clog2(NUM_STEPS).
- WIN_CYCLES, 8, length of the hit window in clk cycles (≥1). Must be less than the tick period minus 2.
- SCORE_W, 8, width of score; score saturates at all-ones.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- start  in  1  one-cycle pulse from the menu FSM; begins a level
- lev  in  3  level code sampled on start: 1..4 valid
- tick  in  1  one-cycle beat pulse from the timer/ticker
- butL, butU, butD, butR  in  1 each  push buttons, already synchronised, active-high
- arrow  out  4  current target arrows {R,D,U,L} for graphics; 0 when no note is shown
- lights  out  4  registered echo of the last judged step's hit mask
- score  out  SCORE_W  count of hit steps
- combo  out  SCORE_W  current run of consecutive hits
- busy  out  1  high while a level is in progress
- done  out  1  level complete; held high

Behaviour:
- Reset (rst=0 at a clk edge) drives arrow=0, lights=0, score=0, combo=0, busy=0, done=0, state=IDLE, step=0. Reset mid-level aborts immediately with no partial output.
- IDLE:
  - On start with lev in 1..4: latch lev, clear score, combo and done, set step=0, busy=1, go to WAIT_BEAT.
  - On start with an invalid lev (0, 5..7): go straight to FIN with score=0.
- WAIT_BEAT:
  - On tick: arrow <= pattern(lev, step), visible in cycle n+1 after the tick in cycle n.
  - Clear hitmask and the window counter, go to WINDOW.
- WINDOW:
  - Each cycle, hitmask |= rising edges of {butR,butD,butU,butL}. Edges are detected against a registered copy of the previous button values.
  - The window counter runs 0..WIN_CYCLES-1, then go to JUDGE.
  - Ticks arriving in WINDOW or JUDGE are ignored and are not queued.
- JUDGE (one cycle):
  - Note step (pattern ≠ 0):
    - Hit if hitmask == pattern: score+1 (saturating), combo+1 (saturating).
    - Otherwise it is a miss: combo <= 0.
  - Rest step (pattern == 0): score and combo are unchanged regardless of presses.
  - In all cases lights <= hitmask and arrow <= 0.
  - If step == NUM_STEPS-1, go to FIN. Otherwise step+1 and return to WAIT_BEAT.
- FIN: busy=0, done=1. Stay in FIN until start, which behaves exactly as start in IDLE.
- start is ignored while busy=1.
- A button held across a window boundary produces no new edge, so it does not count.
- Simultaneous start and tick in IDLE: start is taken and that tick is not consumed as beat 0.
- Pattern lookup is combinational from (lev, step).

Decomposition:
- Package ddr_pkg holds:
  - arrow bit positions: L=0, U=1, D=2, R=3
  - level codes L1..L4 = 1..4
  - the state encoding: IDLE, WAIT_BEAT, WINDOW, JUDGE, FIN
  - the four per-level pattern tables
- Level 1 pattern: step i = 4'b0001 << (i mod 4).
- Level 2 pattern: same as level 1, except every 4th step (i mod 4 == 3) is a rest (0).
- Levels 3 and 4 are defined in the package.
- One sub-module, level_rom(lev, step -> pattern[3:0]), kept separate so that level content changes don't touch the FSM.

Test Plan:
- Perfect play: rst, start with lev=1, 16 ticks 20 cycles apart, press the matching button once per window → arrow sequence 1,2,4,8,…; final score=16, combo=16, done=1, busy=0.
- All misses: lev=1, no presses → score=0, combo=0, lights=0 every step, done=1 after the 16th judge.
- Wrong and extra presses: lev=1, step 0 press butL+butU together, step 1 press butU → step 0 is a miss (hitmask 3 ≠ 1), step 1 is a hit; score=1, combo=1.
- Rest handling: lev=2, press butR during a rest step after 3 hits → score=3, combo=3 unchanged, lights=8.
- Held button and ignored tick: hold butL across two windows → only the first counts. A tick injected during WINDOW leaves step unchanged. start during busy has no effect.
- Reset and invalid level: rst=0 mid-level at step 5 → all outputs 0, state IDLE next cycle. start with lev=6 → done=1 and score=0 one cycle later.

Source files
------------

// File: rtl/ddr_pkg.sv
// Shared definitions for the dance-game play phase: arrow bits, level codes,
// sequencer state encoding and the per-level arrow pattern tables.
package ddr_pkg;

  localparam int ARW_L = 0;
  localparam int ARW_U = 1;
  localparam int ARW_D = 2;
  localparam int ARW_R = 3;

  localparam logic [2:0] LEV_1 = 3'd1;
  localparam logic [2:0] LEV_2 = 3'd2;
  localparam logic [2:0] LEV_3 = 3'd3;
  localparam logic [2:0] LEV_4 = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BEAT,
    WINDOW,
    JUDGE,
    FIN
  } state_t;

  // Nibble i holds step i, so step 0 is the rightmost hex digit.
  localparam logic [15:0][3:0] LEV3_TAB = 64'h80F6_90A5_0C03_8421;
  localparam logic [15:0][3:0] LEV4_TAB = 64'hA5C3_F0F0_8844_2211;

  function automatic logic [3:0] level_pattern(input logic [2:0] lev, input logic [3:0] s);
    logic [3:0] walk;
    walk = 4'b0001 << s[1:0];
    case (lev)
      LEV_1:   return walk;
      LEV_2:   return (s[1:0] == 2'd3) ? 4'd0 : walk;
      LEV_3:   return LEV3_TAB[s];
      LEV_4:   return LEV4_TAB[s];
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/level_rom.sv
// Combinational pattern lookup; level content lives here and in ddr_pkg only.
module level_rom
  import ddr_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic [2:0]       lev,
  input  logic [IDX_W-1:0] step,
  output logic [3:0]       pattern
);

  assign pattern = level_pattern(lev, 4'(step));

endmodule

// File: rtl/note_sequencer.sv
// Play-phase sequencer: steps a level's arrow pattern on beat ticks, opens a
// hit window per step, judges rising-edge presses and keeps score/combo.
module note_sequencer
  import ddr_pkg::*;
#(
  parameter int NUM_STEPS  = 16,
  parameter int WIN_CYCLES = 8,
  parameter int SCORE_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         lev,
  input  logic               tick,
  input  logic               butL,
  input  logic               butU,
  input  logic               butD,
  input  logic               butR,
  output logic [3:0]         arrow,
  output logic [3:0]         lights,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] combo,
  output logic               busy,
  output logic               done
);

  localparam int IDX_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int CNT_W = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;

  state_t           state, state_nxt;
  logic [2:0]       lev_q;
  logic [IDX_W-1:0] step;
  logic [CNT_W-1:0] wcnt;
  logic [3:0]       btn, btn_q, rise, hitmask, pattern;
  logic             lev_ok, last_step, win_end, hit;

  level_rom #(.IDX_W(IDX_W)) u_rom (
    .lev     (lev_q),
    .step    (step),
    .pattern (pattern)
  );

  assign btn       = {butR, butD, butU, butL};
  assign rise      = btn & ~btn_q;
  assign lev_ok    = (lev >= LEV_1) && (lev <= LEV_4);
  assign last_step = (step == IDX_W'(NUM_STEPS - 1));
  assign win_end   = (wcnt == CNT_W'(WIN_CYCLES - 1));
  assign hit       = (pattern != 4'd0) && (hitmask == pattern);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FIN: if (start) state_nxt = lev_ok ? WAIT_BEAT : FIN;
      WAIT_BEAT: if (tick) state_nxt = WINDOW;
      WINDOW:    if (win_end) state_nxt = JUDGE;
      JUDGE:     state_nxt = last_step ? FIN : WAIT_BEAT;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      arrow   <= '0;
      lights  <= '0;
      score   <= '0;
      combo   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      step    <= '0;
      lev_q   <= '0;
      wcnt    <= '0;
      hitmask <= '0;
      btn_q   <= '0;
    end else begin
      btn_q <= btn;
      case (state)
        IDLE, FIN: if (start) begin
          score <= '0;
          combo <= '0;
          step  <= '0;
          if (lev_ok) begin
            lev_q <= lev;
            busy  <= 1'b1;
            done  <= 1'b0;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        WAIT_BEAT: if (tick) begin
          arrow   <= pattern;
          hitmask <= '0;
          wcnt    <= '0;
        end
        WINDOW: begin
          hitmask <= hitmask | rise;
          wcnt    <= wcnt + 1'b1;
        end
        JUDGE: begin
          lights <= hitmask;
          arrow  <= '0;
          // Rest steps leave score and combo untouched whatever was pressed.
          if (pattern != 4'd0) begin
            if (hit) begin
              score <= (&score) ? score : score + 1'b1;
              combo <= (&combo) ? combo : combo + 1'b1;
            end else begin
              combo <= '0;
            end
          end
          if (last_step) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            step <= step + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: vector table, hand-written corner sequences and
// randomized full levels against a step-level scoring model.
module tb_note_sequencer;

  localparam int NS  = 16;
  localparam int WIN = 8;
  localparam int SW  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    lev = 3'd0;
  logic          tick = 1'b0;
  logic          butL = 1'b0, butU = 1'b0, butD = 1'b0, butR = 1'b0;
  logic [3:0]    arrow, lights;
  logic [SW-1:0] score, combo;
  logic          busy, done;

  int n_cmp = 0;
  int n_err = 0;
  int m_score, m_combo;
  int l3[16] = '{1, 2, 4, 8, 3, 0, 12, 0, 5, 10, 0, 9, 6, 15, 0, 8};
  int l4[16] = '{1, 1, 2, 2, 4, 4, 8, 8, 0, 15, 0, 15, 3, 12, 5, 10};

  typedef struct {
    bit         new_lv;
    logic [2:0] lv;
    logic [3:0] press;
    logic [3:0] e_arrow;
    logic [3:0] e_lights;
    int         e_score;
    int         e_combo;
  } vec_t;
  vec_t tv[10];

  always #5 clk = ~clk;

  note_sequencer #(.NUM_STEPS(NS), .WIN_CYCLES(WIN), .SCORE_W(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .lev(lev), .tick(tick),
    .butL(butL), .butU(butU), .butD(butD), .butR(butR),
    .arrow(arrow), .lights(lights), .score(score), .combo(combo),
    .busy(busy), .done(done)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_btn(input logic [3:0] m);
    {butR, butD, butU, butL} = m;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " arrow"}, arrow, 0);
    chk({tag, " lights"}, lights, 0);
    chk({tag, " score"}, score, 0);
    chk({tag, " combo"}, combo, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
  endtask

  function automatic logic [3:0] ref_pat(input int lv, input int i);
    case (lv)
      1:       return 4'(1 << (i % 4));
      2:       return (i % 4 == 3) ? 4'd0 : 4'(1 << (i % 4));
      3:       return 4'(l3[i]);
      4:       return 4'(l4[i]);
      default: return 4'd0;
    endcase
  endfunction

  function automatic void model_judge(input logic [3:0] pat, input logic [3:0] press);
    int top;
    top = (1 << SW) - 1;
    if (pat != 0) begin
      if (press == pat) begin
        m_score = (m_score < top) ? m_score + 1 : top;
        m_combo = (m_combo < top) ? m_combo + 1 : top;
      end else begin
        m_combo = 0;
      end
    end
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
  endtask

  task automatic begin_level(input logic [2:0] lv);
    start = 1'b1;
    lev = lv;
    cyc();
    start = 1'b0;
    m_score = 0;
    m_combo = 0;
  endtask

  // One beat: tick, then a one-cycle press at window offset off (1..WIN), then judge.
  task automatic play_step(input logic [3:0] press, input int off, input bit inj,
                           input logic [3:0] e_arrow, input logic [3:0] e_lights,
                           input int es, input int ec, input string tag);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk({tag, " arrow"}, arrow, e_arrow);
    for (int k = 1; k <= WIN + 1; k++) begin
      set_btn((k == off) ? press : 4'h0);
      tick = inj && (k == 4);
      cyc();
    end
    tick = 1'b0;
    chk({tag, " lights"}, lights, e_lights);
    chk({tag, " score"}, score, es);
    chk({tag, " combo"}, combo, ec);
    chk({tag, " arrow_clr"}, arrow, 0);
  endtask

  // mode 0: perfect, 1: no presses, 2: random mix
  task automatic play_level(input int lv, input int mode, input string tag);
    logic [3:0] pat, press;
    begin_level(3'(lv));
    chk({tag, " busy_on"}, busy, 1);
    chk({tag, " done_off"}, done, 0);
    chk({tag, " score_clr"}, score, 0);
    for (int i = 0; i < NS; i++) begin
      pat = ref_pat(lv, i);
      case (mode)
        0:       press = pat;
        1:       press = 4'h0;
        default: press = ($urandom_range(0, 2) != 0) ? pat : 4'($urandom_range(0, 15));
      endcase
      model_judge(pat, press);
      play_step(press, int'($urandom_range(1, WIN)), 1'b0, pat, press, m_score, m_combo,
                $sformatf("%s s%0d", tag, i));
      repeat ($urandom_range(0, 6)) cyc();
    end
    chk({tag, " done_end"}, done, 1);
    chk({tag, " busy_end"}, busy, 0);
  endtask

  initial begin
    tv[0] = '{1'b1, 3'd1, 4'h3, 4'h1, 4'h3, 0, 0};
    tv[1] = '{1'b0, 3'd1, 4'h2, 4'h2, 4'h2, 1, 1};
    tv[2] = '{1'b0, 3'd1, 4'h4, 4'h4, 4'h4, 2, 2};
    tv[3] = '{1'b0, 3'd1, 4'h0, 4'h8, 4'h0, 2, 0};
    tv[4] = '{1'b0, 3'd1, 4'h1, 4'h1, 4'h1, 3, 1};
    tv[5] = '{1'b1, 3'd2, 4'h1, 4'h1, 4'h1, 1, 1};
    tv[6] = '{1'b0, 3'd2, 4'h2, 4'h2, 4'h2, 2, 2};
    tv[7] = '{1'b0, 3'd2, 4'h4, 4'h4, 4'h4, 3, 3};
    tv[8] = '{1'b0, 3'd2, 4'h8, 4'h0, 4'h8, 3, 3};
    tv[9] = '{1'b0, 3'd2, 4'h1, 4'h1, 4'h1, 4, 4};

    // Reset state
    cyc();
    cyc();
    chk_zero("reset");
    rst = 1'b1;

    // start and tick together: tick must not become beat 0
    start = 1'b1;
    lev = 3'd1;
    tick = 1'b1;
    cyc();
    start = 1'b0;
    tick = 1'b0;
    cyc();
    cyc();
    chk("st_tick arrow", arrow, 0);
    chk("st_tick busy", busy, 1);
    play_step(4'h1, 2, 1'b0, 4'h1, 4'h1, 1, 1, "st_tick s0");

    // Vector table
    for (int i = 0; i < 10; i++) begin
      if (tv[i].new_lv) begin
        do_reset();
        begin_level(tv[i].lv);
      end
      play_step(tv[i].press, 3, 1'b0, tv[i].e_arrow, tv[i].e_lights,
                tv[i].e_score, tv[i].e_combo, $sformatf("vec%0d", i));
    end

    // Invalid level from IDLE
    do_reset();
    begin_level(3'd6);
    chk("inv6 done", done, 1);
    chk("inv6 score", score, 0);
    chk("inv6 busy", busy, 0);

    // Perfect play, then invalid level from FIN clears score
    play_level(1, 0, "perfect");
    chk("perfect score", score, 16);
    chk("perfect combo", combo, 16);
    begin_level(3'd0);
    chk("inv0 score", score, 0);
    chk("inv0 done", done, 1);
    chk("inv0 busy", busy, 0);

    // All misses
    play_level(1, 1, "miss");
    chk("miss score", score, 0);
    chk("miss combo", combo, 0);

    // Held button across windows, ignored tick, start while busy (level 4 starts 1,1,2)
    begin_level(3'd4);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("hold s0 arrow", arrow, 1);
    for (int k = 1; k <= WIN + 1; k++) begin
      butL = 1'b1;
      cyc();
    end
    chk("hold s0 lights", lights, 1);
    chk("hold s0 score", score, 1);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("hold s1 arrow", arrow, 1);
    for (int k = 1; k <= WIN + 1; k++) begin
      tick = (k == 4);
      cyc();
    end
    tick = 1'b0;
    butL = 1'b0;
    chk("hold s1 lights", lights, 0);
    chk("hold s1 score", score, 1);
    chk("hold s1 combo", combo, 0);
    start = 1'b1;
    lev = 3'd1;
    cyc();
    start = 1'b0;
    chk("busy_start busy", busy, 1);
    repeat (3) cyc();
    chk("no_queued_tick arrow", arrow, 0);
    play_step(4'h2, 5, 1'b0, 4'h2, 4'h2, 2, 1, "hold s2");

    // Reset mid-level at step 5
    do_reset();
    begin_level(3'd1);
    for (int i = 0; i < 5; i++)
      play_step(ref_pat(1, i), 2, 1'b0, ref_pat(1, i), ref_pat(1, i), i + 1, i + 1,
                $sformatf("midrst s%0d", i));
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("midrst s5 arrow", arrow, 2);
    butU = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    butU = 1'b0;
    chk_zero("midrst");
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
    chk("midrst idle arrow", arrow, 0);
    chk("midrst idle busy", busy, 0);

    // Randomized levels
    for (int r = 0; r < 6; r++)
      play_level((r < 4) ? r + 1 : int'($urandom_range(1, 4)), 2, $sformatf("rnd%0d", r));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
